// File: rtl/dual_core_mem_arbiter.sv
// rtl/dual_core_mem_arbiter.sv - round-robin arbiter of two core LSU ports onto one shared data-memory port
module dual_core_mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_LOCK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c0_req,
    input  logic                  c0_we,
    input  logic [ADDR_W-1:0]     c0_addr,
    input  logic [DATA_W-1:0]     c0_wdata,
    input  logic [DATA_W/8-1:0]   c0_be,
    input  logic                  c0_lock,
    output logic                  c0_gnt,
    output logic                  c0_rvalid,
    output logic [DATA_W-1:0]     c0_rdata,
    input  logic                  c1_req,
    input  logic                  c1_we,
    input  logic [ADDR_W-1:0]     c1_addr,
    input  logic [DATA_W-1:0]     c1_wdata,
    input  logic [DATA_W/8-1:0]   c1_be,
    input  logic                  c1_lock,
    output logic                  c1_gnt,
    output logic                  c1_rvalid,
    output logic [DATA_W-1:0]     c1_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  owner,
    output logic                  lock_timeout
);
    localparam int CNT_W = $clog2(MAX_LOCK_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT_RSP, LOCKED} state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             owner_q, owner_d;
    logic             lock_q, lock_d;
    logic             hold_q, hold_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    logic [1:0] req;
    logic       sel, sel_req, sel_lock, handshake, lock_expire;

    // Requests are ignored while reset is asserted so every output reads 0.
    assign req = {c1_req, c0_req} & {2{rst_n}};

    // A core left waiting on mem_gnt=0 keeps the port even if the other core arrives.
    always_comb begin
        sel = owner_q;
        if (state_q == IDLE) begin
            if (hold_q && req[owner_q]) sel = owner_q;
            else if (req == 2'b11)      sel = prio_q;
            else if (req[1])            sel = 1'b1;
            else if (req[0])            sel = 1'b0;
        end
    end

    assign sel_req     = req[sel];
    assign sel_lock    = sel ? c1_lock : c0_lock;
    assign handshake   = (state_q != WAIT_RSP) && sel_req && mem_gnt;
    assign lock_expire = (state_q == LOCKED) && !sel_req && sel_lock &&
                         (lock_cnt_q == CNT_W'(MAX_LOCK_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            owner_q    <= 1'b0;
            lock_q     <= 1'b0;
            hold_q     <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            lock_q     <= lock_d;
            hold_q     <= hold_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        hold_d     = 1'b0;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    owner_d = sel;
                    lock_d  = sel_lock;
                    state_d = WAIT_RSP;
                end else if (sel_req) begin
                    owner_d = sel;
                    hold_d  = 1'b1;
                end
            end
            WAIT_RSP: begin
                if (mem_rvalid) begin
                    if (lock_q) begin
                        state_d    = LOCKED;
                        lock_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        prio_d  = ~owner_q;
                    end
                end
            end
            LOCKED: begin
                if (handshake) begin
                    lock_d     = sel_lock;
                    state_d    = WAIT_RSP;
                    lock_cnt_d = '0;
                end else if (!sel_req) begin
                    if (!sel_lock || lock_expire) begin
                        state_d = IDLE;
                        prio_d  = ~owner_q;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_be       = '0;
        c0_gnt       = 1'b0;
        c1_gnt       = 1'b0;
        c0_rvalid    = 1'b0;
        c1_rvalid    = 1'b0;
        c0_rdata     = '0;
        c1_rdata     = '0;
        owner        = sel;
        lock_timeout = lock_expire;
        if (state_q != WAIT_RSP && sel_req) begin
            mem_req   = 1'b1;
            mem_we    = sel ? c1_we    : c0_we;
            mem_addr  = sel ? c1_addr  : c0_addr;
            mem_wdata = sel ? c1_wdata : c0_wdata;
            mem_be    = sel ? c1_be    : c0_be;
        end
        if (handshake) begin
            c0_gnt = ~sel;
            c1_gnt = sel;
        end
        if (state_q == WAIT_RSP && mem_rvalid) begin
            if (owner_q) begin
                c1_rvalid = 1'b1;
                c1_rdata  = mem_rdata;
            end else begin
                c0_rvalid = 1'b1;
                c0_rdata  = mem_rdata;
            end
        end
    end
endmodule

// File: doc/dual_core_mem_arbiter.md
Name: dual_core_mem_arbiter

Overview:
- Arbitrates the two cores of dual_core_riscv onto one shared data-memory port.
- Round-robin fairness, one outstanding transaction at a time.
- Optional bus lock lets a core do atomic read-modify-write sequences without interleaving.
- Sits between the per-core LSU ports and the shared data RAM inside dual_core_riscv.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_LOCK_CYCLES, 16, idle cycles allowed in LOCKED before forced release; must be >=1.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- cN_req  in  1  core N request (N=0,1); held until cN_gnt.
- cN_we  in  1  write enable.
- cN_addr  in  ADDR_W  address.
- cN_wdata  in  DATA_W  write data.
- cN_be  in  DATA_W/8  byte enables.
- cN_lock  in  1  keep ownership after this transaction.
- cN_gnt  out  1  request accepted this cycle.
- cN_rvalid  out  1  response (read data or write ack).
- cN_rdata  out  DATA_W  read data.
- mem_req  out  1  request to memory.
- mem_we  out  1  write enable to memory.
- mem_addr  out  ADDR_W  address to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_be  out  DATA_W/8  byte enables to memory.
- mem_gnt  in  1  memory accepts request.
- mem_rvalid  in  1  memory response valid; exactly one per accepted request, >=1 cycle after accept.
- mem_rdata  in  DATA_W  memory read data.
- owner  out  1  core currently selected or owning the bus.
- lock_timeout  out  1  one-cycle pulse on watchdog release.

Behaviour:
- State register: IDLE, WAIT_RSP, LOCKED.
- Registered fields: prio (1b), owner (1b), lock_q (1b), lock_cnt (clog2(MAX_LOCK_CYCLES+1) bits).
- Reset values: state=IDLE, prio=0, owner=0, lock_q=0, lock_cnt=0, lock_timeout=0.
- All combinational outputs are 0 in reset because state is IDLE and the cores' reqs are ignored.
- Request path (mem_req/we/addr/wdata/be) is a combinational mux of the selected core; zero added latency.
- When mem_req=0, mem_we and mem_be are driven 0.
- IDLE selection:
  - Only one core requesting: select that core.
  - Both requesting: select prio.
  - owner output shows the selected core.
  - cSel_gnt = mem_gnt & mem_req.
  - On handshake: owner latched, lock_q <= cSel_lock, go WAIT_RSP.
- WAIT_RSP:
  - mem_req = 0; no grants to either core.
  - mem_rvalid is routed combinationally to c[owner]_rvalid / c[owner]_rdata; the other core sees rvalid=0.
  - cN_rdata is 0 whenever cN_rvalid=0.
  - On mem_rvalid, if lock_q=1: go LOCKED, lock_cnt <= 0.
  - On mem_rvalid, if lock_q=0: go IDLE, prio <= ~owner.
- LOCKED:
  - Only c[owner] is forwarded; the other core's req is masked, with gnt=0.
  - On owner handshake: lock_q <= c[owner]_lock, go WAIT_RSP, lock_cnt <= 0.
  - Owner req=0 and owner lock=0: go IDLE, prio <= ~owner.
  - Owner req=0 and lock=1: lock_cnt++.
  - When lock_cnt reaches MAX_LOCK_CYCLES-1 and would increment: go IDLE, prio <= ~owner, lock_timeout=1 for that cycle.
- Handshake with mem_gnt=0: request stays presented. Selection may not change while mem_gnt=0 and the selected req is still high; the selected core is held even if the other core raises req.
- Stray mem_rvalid in IDLE or LOCKED: ignored, no cN_rvalid.
- Reset asserted mid-transaction: immediate return to reset values. Any in-flight response is dropped; cores must reissue.
- Simultaneous new request from the same core in the mem_rvalid cycle: not granted until the next cycle (IDLE/LOCKED evaluation).

Test Plan:
- Single requester: c0 read addr 0x100, mem_gnt=1, mem_rvalid 2 cycles later with 0xDEADBEEF -> c0_gnt same cycle as req; c0_rvalid=1, c0_rdata=0xDEADBEEF; c1_rvalid=0; prio=1 after.
- Contention: c0 and c1 both request continuously, memory latency 1 -> grants alternate c0,c1,c0,c1 starting with c0 after reset.
- Lock: c1 issues read with lock=1, then write with lock=0 while c0 requests throughout -> c0_gnt stays 0 until c1's write response; then c0 granted next.
- Lock timeout with MAX_LOCK_CYCLES=16: c0 locked read completes, c0 holds lock=1 with req=0 -> lock_timeout pulses exactly 16 cycles after the response cycle; c1 granted the following cycle.
- Backpressure: mem_gnt=0 for 5 cycles with c0 selected; c1 raises req in cycle 2 -> mem_addr remains c0's; c0_gnt in the cycle mem_gnt=1.
- Reset mid-op: assert rst_n=0 in WAIT_RSP -> all outputs 0 asynchronously; a mem_rvalid after release produces no cN_rvalid.
